// File: rtl/ft_timer_mc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ft_pkg : shared FSM encoding, default costs and helpers for the      |
// |          ft_timer_mc multi-channel time accountant.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ft_state_e;

    localparam int c_SYNC_COST_DEF   = 3;
    localparam int c_READ_LAT_DEF    = 1;
    localparam int c_WRITE_LAT_DEF   = 1;
    localparam int c_ACC_HEADROOM    = 8;

    function automatic logic [3:0] f_popcount8(input logic [7:0] i_v);
        logic [3:0] v_sum;
        v_sum = '0;
        for (int i = 0; i < 8; i++) begin
            v_sum = v_sum + {3'b000, i_v[i]};
        end
        return v_sum;
    endfunction

endpackage : ft_pkg
`default_nettype wire

// File: rtl/ft_timer_mc_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ft_timer_mc_if : control/status bundle of ft_timer_mc.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface ft_timer_mc_if #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 64
);
    logic              sim_start;
    logic              sim_end;
    logic              clear;
    logic              ext_stall;
    logic [N_CH-1:0]   bus_read;
    logic [N_CH-1:0]   bus_write;
    logic [N_CH-1:0]   bus_stall;
    logic [15:0]       sync_interval;
    logic [1:0]        state;
    logic              is_stalled;
    logic              is_sim;
    logic [CNT_W-1:0]  wall_time;
    logic [CNT_W-1:0]  emu_time;
    logic [CNT_W-1:0]  sim_time;
    logic [CNT_W-1:0]  freeze_time;
    logic [31:0]       sync_count;
    logic              snap_req;
    logic              snap_ack;
    logic [CNT_W-1:0]  snap_wall;
    logic [CNT_W-1:0]  snap_emu;
    logic [CNT_W-1:0]  snap_sim;
    logic [CNT_W-1:0]  snap_freeze;

    modport master (
        output sim_start, sim_end, clear, ext_stall,
        output bus_read, bus_write, bus_stall, sync_interval, snap_req,
        input  state, is_stalled, is_sim,
        input  wall_time, emu_time, sim_time, freeze_time, sync_count,
        input  snap_ack, snap_wall, snap_emu, snap_sim, snap_freeze
    );

    modport slave (
        input  sim_start, sim_end, clear, ext_stall,
        input  bus_read, bus_write, bus_stall, sync_interval, snap_req,
        output state, is_stalled, is_sim,
        output wall_time, emu_time, sim_time, freeze_time, sync_count,
        output snap_ack, snap_wall, snap_emu, snap_sim, snap_freeze
    );

endinterface : ft_timer_mc_if
`default_nettype wire

// File: rtl/ft_timer_mc_sat_acc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ft_sat_acc : W-bit accumulator that clamps at all-ones, sum formed   |
// |              with 8 bits of headroom so large steps cannot wrap.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ft_sat_acc #(
    parameter int W = 64
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    input  wire logic           i_clr,
    input  wire logic           i_en,
    input  wire logic [W+7:0]   i_inc,
    output logic      [W-1:0]   o_val
);

    logic [W-1:0] r_acc;
    logic [W+7:0] w_sum;
    logic [W-1:0] w_next;

    assign w_sum  = {8'd0, r_acc} + i_inc;
    assign w_next = (|w_sum[W+7:W]) ? {W{1'b1}} : w_sum[W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_next;
        end
    end

    assign o_val = r_acc;

endmodule : ft_sat_acc
`default_nettype wire

// File: rtl/ft_timer_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ft_timer_mc : wall/emu/sim/freeze time accounting over N_CH buses.   |
// | Optional snapshot capture under macro FT_TIMER_SNAPSHOT_EN.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ft_timer_mc
    import ft_pkg::*;
#(
    parameter int N_CH          = 2,
    parameter int CNT_W         = 64,
    parameter int READ_LATENCY  = c_READ_LAT_DEF,
    parameter int WRITE_LATENCY = c_WRITE_LAT_DEF,
    parameter int SYNC_COST     = c_SYNC_COST_DEF
) (
    input  wire logic     clock,
    input  wire logic     reset_n,
    ft_timer_mc_if.slave  bus
);

    localparam int c_SUM_W = CNT_W + c_ACC_HEADROOM;

    ft_state_e          r_state;
    ft_state_e          w_state_nxt;
    logic               w_cnt_clr;
    logic               w_cnt_en;
    logic               w_stalled;
    logic               w_active;
    logic               w_sync_take;
    logic [15:0]        r_sync_cnt;
    logic [15:0]        w_sync_nxt;
    logic [3:0]         w_pop_rd;
    logic [3:0]         w_pop_wr;
    logic [c_SUM_W-1:0] w_inc_wall;
    logic [c_SUM_W-1:0] w_inc_freeze;
    logic [c_SUM_W-1:0] w_inc_sim;
    logic [c_SUM_W-1:0] w_inc_emu;
    logic [39:0]        w_inc_sync;
    logic [CNT_W-1:0]   w_wall;
    logic [CNT_W-1:0]   w_emu;
    logic [CNT_W-1:0]   w_sim;
    logic [CNT_W-1:0]   w_freeze;
    logic [31:0]        w_sync_count;

    assign w_stalled = (|bus.bus_stall) | bus.ext_stall;
    assign w_active  = (|bus.bus_read) | (|bus.bus_write);
    assign w_pop_rd  = f_popcount8(8'(bus.bus_read));
    assign w_pop_wr  = f_popcount8(8'(bus.bus_write));
    assign w_cnt_en  = (r_state == ST_RUN);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // clear wins over start/end; a fresh start from IDLE also zeroes everything
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        if (bus.clear) begin
            w_state_nxt = ST_IDLE;
            w_cnt_clr   = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.sim_start && !bus.sim_end) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_clr   = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.sim_end) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.sim_start && !bus.sim_end) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_sync_take = !w_stalled && (bus.sync_interval != 16'd0) &&
                         (r_sync_cnt == (bus.sync_interval - 16'd1));

    // a shrunken interval below the current count restarts the period silently
    always_comb begin
        w_sync_nxt = r_sync_cnt;
        if (bus.sync_interval == 16'd0) begin
            w_sync_nxt = '0;
        end else if (r_sync_cnt >= bus.sync_interval) begin
            w_sync_nxt = '0;
        end else if (w_stalled) begin
            w_sync_nxt = r_sync_cnt;
        end else if (w_sync_take) begin
            w_sync_nxt = '0;
        end else begin
            w_sync_nxt = r_sync_cnt + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_sync_cnt <= '0;
        end else if (w_cnt_en) begin
            r_sync_cnt <= w_sync_nxt;
        end
    end

    always_comb begin
        w_inc_wall   = c_SUM_W'(1);
        w_inc_freeze = c_SUM_W'(!w_stalled);
        w_inc_emu    = w_sync_take ? c_SUM_W'(SYNC_COST) : c_SUM_W'(1);
        w_inc_sync   = 40'(w_sync_take);
        if (w_stalled) begin
            w_inc_sim = '0;
        end else if (w_active) begin
            w_inc_sim = c_SUM_W'(READ_LATENCY)  * c_SUM_W'(w_pop_rd) +
                        c_SUM_W'(WRITE_LATENCY) * c_SUM_W'(w_pop_wr);
        end else begin
            w_inc_sim = c_SUM_W'(1);
        end
    end

    ft_sat_acc #(.W(CNT_W)) u_acc_wall (
        .clk(clock), .rst_n(reset_n), .i_clr(w_cnt_clr), .i_en(w_cnt_en),
        .i_inc(w_inc_wall), .o_val(w_wall)
    );

    ft_sat_acc #(.W(CNT_W)) u_acc_emu (
        .clk(clock), .rst_n(reset_n), .i_clr(w_cnt_clr), .i_en(w_cnt_en),
        .i_inc(w_inc_emu), .o_val(w_emu)
    );

    ft_sat_acc #(.W(CNT_W)) u_acc_sim (
        .clk(clock), .rst_n(reset_n), .i_clr(w_cnt_clr), .i_en(w_cnt_en),
        .i_inc(w_inc_sim), .o_val(w_sim)
    );

    ft_sat_acc #(.W(CNT_W)) u_acc_freeze (
        .clk(clock), .rst_n(reset_n), .i_clr(w_cnt_clr), .i_en(w_cnt_en),
        .i_inc(w_inc_freeze), .o_val(w_freeze)
    );

    ft_sat_acc #(.W(32)) u_acc_sync (
        .clk(clock), .rst_n(reset_n), .i_clr(w_cnt_clr), .i_en(w_cnt_en),
        .i_inc(w_inc_sync), .o_val(w_sync_count)
    );

    assign bus.state       = r_state;
    assign bus.is_sim      = (r_state == ST_RUN);
    assign bus.is_stalled  = w_stalled;
    assign bus.wall_time   = w_wall;
    assign bus.emu_time    = w_emu;
    assign bus.sim_time    = w_sim;
    assign bus.freeze_time = w_freeze;
    assign bus.sync_count  = w_sync_count;

`ifdef FT_TIMER_SNAPSHOT_EN
    logic [CNT_W-1:0] r_snap_wall;
    logic [CNT_W-1:0] r_snap_emu;
    logic [CNT_W-1:0] r_snap_sim;
    logic [CNT_W-1:0] r_snap_freeze;
    logic             r_snap_ack;

    // captures the counter values as they stood before this cycle's update
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_snap_wall   <= '0;
            r_snap_emu    <= '0;
            r_snap_sim    <= '0;
            r_snap_freeze <= '0;
            r_snap_ack    <= 1'b0;
        end else begin
            r_snap_ack <= bus.snap_req;
            if (bus.snap_req) begin
                r_snap_wall   <= w_wall;
                r_snap_emu    <= w_emu;
                r_snap_sim    <= w_sim;
                r_snap_freeze <= w_freeze;
            end
        end
    end

    assign bus.snap_ack    = r_snap_ack;
    assign bus.snap_wall   = r_snap_wall;
    assign bus.snap_emu    = r_snap_emu;
    assign bus.snap_sim    = r_snap_sim;
    assign bus.snap_freeze = r_snap_freeze;
`else
    logic w_snap_unused;
    assign w_snap_unused   = bus.snap_req;
    assign bus.snap_ack    = 1'b0;
    assign bus.snap_wall   = '0;
    assign bus.snap_emu    = '0;
    assign bus.snap_sim    = '0;
    assign bus.snap_freeze = '0;
`endif

endmodule : ft_timer_mc
`default_nettype wire

// File: tb/tb_ft_timer_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ft_timer_mc : directed self-checking bench for ft_timer_mc.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ft_timer_mc;

    localparam int c_N_CH  = 2;
    localparam int c_CNT_W = 16;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    ft_timer_mc_if #(.N_CH(c_N_CH), .CNT_W(c_CNT_W)) u_if ();

    ft_timer_mc #(
        .N_CH(c_N_CH), .CNT_W(c_CNT_W),
        .READ_LATENCY(2), .WRITE_LATENCY(3), .SYNC_COST(3)
    ) u_dut (
        .clock  (clk),
        .reset_n(rst_n),
        .bus    (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic check_all(input string tag, input logic [63:0] e_wall,
                             input logic [63:0] e_emu, input logic [63:0] e_sim,
                             input logic [63:0] e_frz, input logic [63:0] e_sc);
        check_val({tag, ".wall"},   u_if.wall_time,   e_wall);
        check_val({tag, ".emu"},    u_if.emu_time,    e_emu);
        check_val({tag, ".sim"},    u_if.sim_time,    e_sim);
        check_val({tag, ".freeze"}, u_if.freeze_time, e_frz);
        check_val({tag, ".syncs"},  u_if.sync_count,  e_sc);
    endtask

    logic        exp_ack;
    logic [15:0] exp_snap_scale;

    initial begin
        n_chk  = 0;
        n_pass = 0;
`ifdef FT_TIMER_SNAPSHOT_EN
        exp_ack        = 1'b1;
        exp_snap_scale = 16'hFFFF;
`else
        exp_ack        = 1'b0;
        exp_snap_scale = 16'h0000;
`endif
        rst_n                = 1'b0;
        u_if.sim_start       = 1'b0;
        u_if.sim_end         = 1'b0;
        u_if.clear           = 1'b0;
        u_if.ext_stall       = 1'b0;
        u_if.bus_read        = '0;
        u_if.bus_write       = '0;
        u_if.bus_stall       = '0;
        u_if.sync_interval   = 16'd0;
        u_if.snap_req        = 1'b0;

        run(3);
        check_val("rst.state", u_if.state, 2'd0);
        check_val("rst.is_sim", u_if.is_sim, 1'b0);
        check_val("rst.snap_ack", u_if.snap_ack, 1'b0);
        check_all("rst", 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        u_if.bus_stall = 2'b10; #1;
        check_val("stall.bus", u_if.is_stalled, 1'b1);
        u_if.bus_stall = 2'b00; u_if.ext_stall = 1'b1; #1;
        check_val("stall.ext", u_if.is_stalled, 1'b1);
        u_if.ext_stall = 1'b0; #1;
        check_val("stall.none", u_if.is_stalled, 1'b0);

        // 10 RUN cycles with sync every cycle, last one carries sim_end
        u_if.sync_interval = 16'd1;
        u_if.sim_start = 1'b1; tick(); u_if.sim_start = 1'b0;
        check_val("start.state", u_if.state, 2'd1);
        check_val("start.is_sim", u_if.is_sim, 1'b1);
        check_all("start", 0, 0, 0, 0, 0);
        run(9);
        u_if.sim_end = 1'b1; tick(); u_if.sim_end = 1'b0;
        check_val("end.state", u_if.state, 2'd2);
        check_all("run10", 10, 30, 10, 10, 10);
        run(2);
        check_all("done.hold", 10, 30, 10, 10, 10);

        u_if.sim_start = 1'b1; tick(); u_if.sim_start = 1'b0;
        check_val("resume.state", u_if.state, 2'd1);
        check_all("resume", 10, 30, 10, 10, 10);
        u_if.bus_stall = 2'b10; run(5); u_if.bus_stall = 2'b00;
        check_all("stall5", 15, 35, 10, 10, 10);

        u_if.sync_interval = 16'd0;
        u_if.bus_read = 2'b11; u_if.bus_write = 2'b01; tick();
        check_all("lat.rw", 16, 36, 17, 11, 10);
        u_if.bus_read = 2'b00; u_if.bus_write = 2'b11; tick();
        check_val("lat.w2.sim", u_if.sim_time, 23);
        u_if.bus_read = 2'b01; u_if.bus_write = 2'b00; tick();
        u_if.bus_read = 2'b00;
        check_all("lat.r1", 18, 38, 25, 13, 10);

        u_if.sync_interval = 16'd3; run(6);
        check_all("sync3", 24, 48, 31, 19, 12);
        run(2);
        check_val("sync3b.emu", u_if.emu_time, 50);
        // counter sits at 2; shrinking interval to 2 restarts without a sync
        u_if.sync_interval = 16'd2; run(3);
        check_all("shrink", 29, 55, 36, 24, 13);

        u_if.clear = 1'b1; u_if.sim_start = 1'b1; tick();
        u_if.clear = 1'b0; u_if.sim_start = 1'b0;
        check_val("clr.state", u_if.state, 2'd0);
        check_all("clr", 0, 0, 0, 0, 0);
        tick();
        check_val("clr.idle", u_if.state, 2'd0);

        u_if.sim_start = 1'b1; tick(); u_if.sim_start = 1'b0;
        run(4);
        check_val("prerst.wall", u_if.wall_time, 4);
        rst_n = 1'b0; #1;
        check_val("arst.state", u_if.state, 2'd0);
        check_all("arst", 0, 0, 0, 0, 0);
        #2; rst_n = 1'b1; tick();
        check_val("arst.idle", u_if.state, 2'd0);

        u_if.sync_interval = 16'd0;
        u_if.sim_start = 1'b1; tick(); u_if.sim_start = 1'b0;
        run(42);
        check_val("snap.pre.wall", u_if.wall_time, 42);
        u_if.snap_req = 1'b1; tick(); u_if.snap_req = 1'b0;
        check_val("snap.wall", u_if.snap_wall, 16'd42 & exp_snap_scale);
        check_val("snap.emu", u_if.snap_emu, 16'd42 & exp_snap_scale);
        check_val("snap.ack", u_if.snap_ack, exp_ack);
        check_val("snap.live", u_if.wall_time, 43);
        tick();
        check_val("snap.ack.drop", u_if.snap_ack, 1'b0);
        check_val("snap.hold", u_if.snap_wall, 16'd42 & exp_snap_scale);
        u_if.snap_req = 1'b1; tick();
        check_val("snap.held1", u_if.snap_wall, 16'd44 & exp_snap_scale);
        tick();
        check_val("snap.held2", u_if.snap_wall, 16'd45 & exp_snap_scale);
        check_val("snap.held.ack", u_if.snap_ack, exp_ack);
        u_if.snap_req = 1'b0;

        u_if.clear = 1'b1; tick(); u_if.clear = 1'b0;
        u_if.sync_interval = 16'd1;
        u_if.sim_start = 1'b1; tick(); u_if.sim_start = 1'b0;
        run(65540);
        check_all("sat", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 65540);
        u_if.sim_end = 1'b1; tick(); u_if.sim_end = 1'b0;
        check_val("sat.done", u_if.state, 2'd2);
        check_val("sat.hold", u_if.wall_time, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_ft_timer_mc
`default_nettype wire

// File: doc/ft_timer_mc.md
FT_TIMER_MC -- requirements
Module: ft_timer_mc

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of monitored bus channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 64, width of every time counter (16..64).
REQ-003 SHALL have parameter READ_LATENCY, default 1, sim-time cost per channel read.
REQ-004 SHALL have parameter WRITE_LATENCY, default 1, sim-time cost per channel write.
REQ-005 SHALL have parameter SYNC_COST, default 3, emu-time cost of one sync cycle.
REQ-006 SHALL have ports: clock in 1 fabric clock; reset_n in 1 reset.
REQ-007 SHALL have ports: sim_start in 1; sim_end in 1; clear in 1 counter clear; ext_stall in 1.
REQ-008 SHALL have ports: bus_read, bus_write and bus_stall, each in N_CH, one bit per channel.
REQ-009 SHALL have port sync_interval in 16, non-stalled RUN cycles per sync; 0 disables sync.
REQ-010 SHALL have ports: state out 2; is_stalled out 1; is_sim out 1.
REQ-011 SHALL have ports: wall_time, emu_time, sim_time and freeze_time, each out CNT_W.
REQ-012 SHALL have port sync_count out 32, number of syncs taken.
REQ-013 SHALL have ports: snap_req in 1; snap_ack out 1; snap_wall, snap_emu, snap_sim and snap_freeze, each out CNT_W.
REQ-014 SHALL use one clock, clock; reset_n is asynchronous, active-low.

Function
REQ-015 is_stalled SHALL be combinational: OR of bus_stall[*] and ext_stall.
REQ-016 FSM states SHALL be IDLE=0, RUN=1, DONE=2; is_sim = (state==RUN).
REQ-017 IDLE->RUN SHALL occur when sim_start=1 and sim_end=0; all counters, sync counter and sync_count zero on that edge.
REQ-018 RUN->DONE SHALL occur when sim_end=1; DONE holds all counters.
REQ-019 DONE->RUN SHALL occur when sim_start=1 and sim_end=0; counters resume without clearing.
REQ-020 clear=1 SHALL, in any state, zero all counters, go to IDLE, and take priority over sim_start and sim_end.
REQ-021 Counters SHALL update only on cycles with state==RUN.
REQ-022 In RUN, wall_time SHALL add 1 per cycle; freeze_time SHALL add 1 per non-stalled cycle.
REQ-023 In RUN, sim_time SHALL add 0 if stalled.
REQ-024 In RUN and not stalled, sim_time SHALL add READ_LATENCY x popcount(bus_read) + WRITE_LATENCY x popcount(bus_write), or 1 if no channel is accessing.
REQ-025 Internal sync counter SHALL increment on non-stalled RUN cycles.
REQ-026 When sync counter == sync_interval-1, not stalled and sync_interval!=0: emu_time adds SYNC_COST, sync counter resets to 0, sync_count adds 1.
REQ-027 On all other RUN cycles, emu_time SHALL add 1.
REQ-028 Every counter SHALL saturate at all-ones and never wrap; the increment SHALL be computed in CNT_W+8 bits before clamping.
REQ-029 A sync_interval change during RUN SHALL take effect next cycle; if the sync counter is already >= the new value, it resets to 0 without a sync.

Reset
REQ-030 reset_n low SHALL force state=IDLE and zero every counter, sync_count, every snap_* output and snap_ack, asynchronously.
REQ-031 Reset asserted mid-RUN SHALL discard all accumulation; no counter retains a value.

Configuration
REQ-032 With macro FT_TIMER_SNAPSHOT_EN defined, snap_req=1 SHALL latch the four live counters (pre-update values of that cycle) into snap_*, with snap_ack=1 exactly one cycle later, for one cycle.
REQ-033 With FT_TIMER_SNAPSHOT_EN defined, snap_req held high SHALL re-capture every cycle, with snap_ack high every cycle after the first.
REQ-034 Without FT_TIMER_SNAPSHOT_EN, snap ports SHALL remain, snap_* and snap_ack SHALL be constant 0, and no snapshot registers SHALL be built.

Structure
REQ-035 Package ft_pkg SHALL hold the FSM state encoding, the default SYNC_COST, and the default latency constants.
REQ-036 A sub-module ft_sat_acc (parametrised saturating accumulator) SHALL be instantiated once per counter.

Verification
REQ-037 Defaults; start, 10 idle non-stalled cycles, end -> wall=10, freeze=10, sim=10, emu=10 + 2x10 = 30 with sync_interval=1 (sync_count=10).
REQ-038 N_CH=2; one cycle with bus_read=2'b11, bus_write=2'b01, READ_LATENCY=2, WRITE_LATENCY=3 -> sim_time +7.
REQ-039 bus_stall[1]=1 for 5 RUN cycles -> wall +5, emu +5, sim +0, freeze +0, sync_count unchanged.
REQ-040 CNT_W=16, wall preloaded near 16'hFFFF by running 65540 cycles -> wall_time holds 16'hFFFF.
REQ-041 clear and sim_start asserted in the same cycle -> state=IDLE, all counters 0; reset_n pulsed mid-RUN -> immediate zeros.
REQ-042 FT_TIMER_SNAPSHOT_EN, snap_req at wall=42 -> snap_wall=42, snap_ack high one cycle later; without the macro, snap_ack stays 0.
